// File: rtl/mem_stage.sv
// Memory-access stage: handshaked loads/stores, pipeline stall while a request is outstanding.
// Optional misaligned-access detection when MEM_ALIGN_CHECK_EN is defined.
module mem_stage #(
    parameter int IN_W  = 251,
    parameter int OUT_W = 175
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [0:IN_W-1]  in,
    output logic [0:OUT_W-1] out,
    output logic             mem_stall,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [0:31]      dmem_addr,
    output logic [0:3]       dmem_be,
    output logic [0:31]      dmem_wdata,
    input  logic [0:31]      dmem_rdata,
    input  logic             dmem_ack,
    output logic             mem_misalign
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] ld_q, ld_d;

    logic [31:0] next_pc, opb, alu, rdata;
    logic [4:0]  dest_reg, f_dest_reg;
    logic [63:0] fbus_w;
    logic [1:0]  dsize, off, off_a;
    logic        pc_to_reg, reg_write, mem_to_reg, mem_write;
    logic        load_sign, trap, fp_reg_write;
    logic        is_byte, is_half, is_word;
    logic        memop, misalign, mis_hit;
    logic [3:0]  be_c;
    logic [31:0] wdata_c, load_c;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic        unused_fields;

    // Unpack into conventional little-endian locals; numeric values are preserved.
    assign next_pc      = in[0:31];
    assign opb          = in[32:63];
    assign dest_reg     = in[64:68];
    assign alu          = in[69:100];
    assign pc_to_reg    = in[101];
    assign reg_write    = in[103];
    assign mem_to_reg   = in[104];
    assign mem_write    = in[105];
    assign load_sign    = in[106];
    assign dsize        = in[107:108];
    assign trap         = in[179];
    assign f_dest_reg   = in[180:184];
    assign fbus_w       = in[185:248];
    assign fp_reg_write = in[249];
    assign rdata        = dmem_rdata;

    assign unused_fields = ^{in[102], in[109:178], in[250]};

    assign is_byte = (dsize == 2'b00);
    assign is_half = (dsize == 2'b01);
    assign is_word = dsize[1];
    assign off     = alu[1:0];
    assign memop   = (mem_to_reg | mem_write) & ~trap;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = (is_half & off[0]) | (is_word & (off != 2'b00));
    assign off_a    = off;
`else
    assign misalign = 1'b0;
    assign off_a    = is_word ? 2'b00 : (is_half ? {off[1], 1'b0} : off);
`endif

    always_comb begin
        be_c    = 4'b1111;
        wdata_c = opb;
        unique case (1'b1)
            is_byte: begin
                be_c    = 4'b1000 >> off_a;
                wdata_c = {4{opb[7:0]}};
            end
            is_half: begin
                be_c    = off_a[1] ? 4'b0011 : 4'b1100;
                wdata_c = {2{opb[15:0]}};
            end
            is_word: begin
                be_c    = 4'b1111;
                wdata_c = opb;
            end
        endcase
    end

    // Offset 0 is the most significant byte of the word.
    always_comb begin
        lane_b = 8'h00;
        unique case (off_a)
            2'd0: lane_b = rdata[31:24];
            2'd1: lane_b = rdata[23:16];
            2'd2: lane_b = rdata[15:8];
            2'd3: lane_b = rdata[7:0];
        endcase
        lane_h = off_a[1] ? rdata[15:0] : rdata[31:16];
        load_c = rdata;
        unique case (1'b1)
            is_byte: load_c = {{24{load_sign & lane_b[7]}}, lane_b};
            is_half: load_c = {{16{load_sign & lane_h[15]}}, lane_h};
            is_word: load_c = rdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        ld_d      = ld_q;
        mem_stall = 1'b0;
        mis_hit   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                mis_hit = memop & misalign;
                if (memop && !misalign) begin
                    mem_stall = 1'b1;
                    req_d     = 1'b1;
                    we_d      = mem_write;
                    addr_d    = {alu[31:2], 2'b00};
                    be_d      = be_c;
                    wdata_d   = wdata_c;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                mem_stall = 1'b1;
                if (dmem_ack) begin
                    req_d   = 1'b0;
                    ld_d    = mem_write ? 32'h0 : load_c;
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (reset) begin
            mem_stall = 1'b0;
            mis_hit   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            ld_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            ld_q    <= ld_d;
        end
    end

    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_be      = be_q;
    assign dmem_wdata   = wdata_q;
    assign mem_misalign = mis_hit;

    assign out = {
        next_pc,
        alu,
        (state_q == S_DONE) ? ld_q : 32'h0,
        dest_reg,
        reg_write & ~mis_hit,
        mem_to_reg,
        pc_to_reg,
        f_dest_reg,
        fbus_w,
        fp_reg_write,
        trap | mis_hit
    };

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, loads, stores, reset mid-wait, alignment.
module tb_mem_stage;

    logic          clk = 1'b0;
    logic          reset;
    logic [0:250]  in_r;
    logic [0:174]  out;
    logic          mem_stall, dmem_req, dmem_we, dmem_ack, mem_misalign;
    logic [0:31]   dmem_addr, dmem_wdata, dmem_rdata;
    logic [0:3]    dmem_be;

    int checks   = 0;
    int failures = 0;

    logic [31:0] md, ad, wd;
    logic [3:0]  be;
    logic        we;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk          (clk),
        .reset        (reset),
        .in           (in_r),
        .out          (out),
        .mem_stall    (mem_stall),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_be      (dmem_be),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_ack     (dmem_ack),
        .mem_misalign (mem_misalign)
    );

    function automatic logic [0:250] mk(
        input logic [31:0] alu, input logic [31:0] opb,
        input logic m2r, input logic mw, input logic ls,
        input logic [1:0] ds, input logic rw, input logic tr);
        logic [0:250] v;
        v          = '0;
        v[0:31]    = 32'h00001004;
        v[32:63]   = opb;
        v[64:68]   = 5'd7;
        v[69:100]  = alu;
        v[102]     = 1'b1;
        v[103]     = rw;
        v[104]     = m2r;
        v[105]     = mw;
        v[106]     = ls;
        v[107:108] = ds;
        v[109:140] = 32'hDEADBEEF;
        v[141]     = 1'b1;
        v[142:173] = 32'hCAFEF00D;
        v[174:178] = 5'd9;
        v[179]     = tr;
        v[180:184] = 5'd3;
        v[185:248] = 64'h0123456789ABCDEF;
        v[249]     = 1'b1;
        v[250]     = 1'b1;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Starts at cycle 0 of the op; ends inside its DONE cycle.
    task automatic mem_op(input logic [0:250] v, input int k, input logic [31:0] rd,
                          output logic [31:0] o_md, output logic [31:0] o_ad,
                          output logic [3:0] o_be, output logic [31:0] o_wd,
                          output logic o_we);
        in_r = v;
        #1;
        chk("c0_stall", mem_stall, 1);
        chk("c0_req", dmem_req, 0);
        o_ad = '0; o_be = '0; o_wd = '0; o_we = 1'b0;
        for (int c = 1; c <= k; c++) begin
            tick();
            if (c == k) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rd;
            end
            #1;
            chk($sformatf("c%0d_req", c), dmem_req, 1);
            chk($sformatf("c%0d_stall", c), mem_stall, 1);
            if (c == 1) begin
                o_ad = dmem_addr;
                o_be = dmem_be;
                o_wd = dmem_wdata;
                o_we = dmem_we;
            end
        end
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        #1;
        chk("done_stall", mem_stall, 0);
        chk("done_req", dmem_req, 0);
        o_md = out[64:95];
    endtask

    initial begin
        reset      = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        in_r       = mk(32'h100, 0, 1, 0, 1, 2'b10, 1, 0);
        #2;
        chk("rst_stall", mem_stall, 0);
        chk("rst_req", dmem_req, 0);
        chk("rst_be", dmem_be, 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_mis", mem_misalign, 0);
        chk("rst_md", out[64:95], 0);
        tick();
        in_r  = mk(32'h10, 0, 0, 0, 0, 2'b10, 1, 0);
        reset = 1'b0;
        #1;

        chk("alu_stall", mem_stall, 0);
        chk("alu_res", out[32:63], 32'h10);
        chk("alu_md", out[64:95], 0);
        chk("alu_rw", out[101], 1);
        chk("alu_pc", out[0:31], 32'h00001004);
        chk("alu_dst", out[96:100], 7);
        chk("alu_fbus", out[109:172], 64'h0123456789ABCDEF);
        chk("alu_fdst", out[104:108], 3);
        chk("alu_trap", out[174], 0);
        dmem_ack = 1'b1;
        #1;
        chk("idle_ack_stall", mem_stall, 0);
        tick();
        dmem_ack = 1'b0;
        #1;
        chk("idle_ack_req", dmem_req, 0);
        chk("idle_ack_md", out[64:95], 0);

        mem_op(mk(32'h100, 0, 1, 0, 1, 2'b10, 1, 0), 3, 32'h89ABCDEF, md, ad, be, wd, we);
        chk("lw_md", md, 32'h89ABCDEF);
        chk("lw_addr", ad, 32'h100);
        chk("lw_be", be, 4'b1111);
        chk("lw_we", we, 0);
        chk("lw_rw", out[101], 1);
        tick();

        mem_op(mk(32'h103, 0, 1, 0, 1, 2'b00, 1, 0), 1, 32'h112233F0, md, ad, be, wd, we);
        chk("lb_md", md, 32'hFFFFFFF0);
        chk("lb_be", be, 4'b0001);
        chk("lb_addr", ad, 32'h100);
        tick();
        mem_op(mk(32'h103, 0, 1, 0, 0, 2'b00, 1, 0), 2, 32'h112233F0, md, ad, be, wd, we);
        chk("lbu_md", md, 32'h000000F0);
        tick();

        mem_op(mk(32'h102, 0, 1, 0, 1, 2'b01, 1, 0), 1, 32'h1234ABCD, md, ad, be, wd, we);
        chk("lh_md", md, 32'hFFFFABCD);
        chk("lh_be", be, 4'b0011);
        tick();
        mem_op(mk(32'h100, 0, 1, 0, 0, 2'b01, 1, 0), 1, 32'h80017FFF, md, ad, be, wd, we);
        chk("lhu_md", md, 32'h00008001);
        chk("lhu_be", be, 4'b1100);
        tick();

        mem_op(mk(32'h202, 32'h0000BEEF, 0, 1, 0, 2'b01, 1, 0), 2, 32'h0, md, ad, be, wd, we);
        chk("sh_be", be, 4'b0011);
        chk("sh_wd", wd, 32'hBEEFBEEF);
        chk("sh_addr", ad, 32'h200);
        chk("sh_we", we, 1);
        chk("sh_md", md, 0);
        chk("sh_rw", out[101], 1);
        tick();

        mem_op(mk(32'h201, 32'h12345678, 0, 1, 0, 2'b00, 0, 0), 1, 32'h0, md, ad, be, wd, we);
        chk("sb_be", be, 4'b0100);
        chk("sb_wd", wd, 32'h78787878);
        chk("sb_rw", out[101], 0);
        tick();

        in_r = mk(32'h100, 0, 1, 0, 1, 2'b10, 1, 1);
        #1;
        chk("trap_stall", mem_stall, 0);
        chk("trap_out", out[174], 1);
        tick();
        chk("trap_req", dmem_req, 0);

`ifdef MEM_ALIGN_CHECK_EN
        in_r = mk(32'h102, 0, 1, 0, 1, 2'b10, 1, 0);
        #1;
        chk("mis_pulse", mem_misalign, 1);
        chk("mis_stall", mem_stall, 0);
        chk("mis_trap", out[174], 1);
        chk("mis_rw", out[101], 0);
        tick();
        chk("mis_req", dmem_req, 0);
        in_r = mk(32'h10, 0, 0, 0, 0, 2'b10, 1, 0);
        #1;
        chk("mis_clear", mem_misalign, 0);
        tick();
`else
        mem_op(mk(32'h102, 0, 1, 0, 1, 2'b10, 1, 0), 1, 32'h01020304, md, ad, be, wd, we);
        chk("wal_addr", ad, 32'h100);
        chk("wal_md", md, 32'h01020304);
        chk("wal_mis", mem_misalign, 0);
        chk("wal_trap", out[174], 0);
        tick();
`endif

        in_r = mk(32'h300, 0, 1, 0, 1, 2'b10, 1, 0);
        tick();
        chk("rw_req_up", dmem_req, 1);
        tick();
        reset = 1'b1;
        #1;
        chk("rw_req_drop", dmem_req, 0);
        chk("rw_stall", mem_stall, 0);
        in_r = mk(32'h20, 0, 0, 0, 0, 2'b10, 1, 0);
        tick();
        reset    = 1'b0;
        dmem_ack = 1'b1;
        dmem_rdata = 32'hFFFFFFFF;
        #1;
        chk("rw_ack_stall", mem_stall, 0);
        chk("rw_ack_md", out[64:95], 0);
        tick();
        dmem_ack = 1'b0;
        #1;
        chk("rw_after_md", out[64:95], 0);
        chk("rw_after_req", dmem_req, 0);
        chk("rw_after_stall", mem_stall, 0);
        tick();

        mem_op(mk(32'h104, 0, 1, 0, 0, 2'b10, 1, 0), 1, 32'hA5A5A5A5, md, ad, be, wd, we);
        chk("post_rst_md", md, 32'hA5A5A5A5);
        chk("post_rst_addr", ad, 32'h104);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage pipeline. Consumes the 251-bit EX/MEM bundle and runs loads and stores against a handshaked data memory. Holds the pipeline with a stall while an access is outstanding. Produces the 175-bit bundle captured by the MEM/WB register.

## Interface
Parameters:
- `IN_W`, 251: EX/MEM bundle width.
- `OUT_W`, 175: MEM/WB bundle width.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high.
- `in`  in  [0:250]  EX/MEM bundle, MSB-0 numbering:
  - nextPC [0:31], opB/store data [32:63], destReg [64:68], aluResult/address [69:100]
  - PCtoReg 101, RegToPC 102, RegWrite 103, MemToReg 104, MemWrite 105, loadSign 106, DSize [107:108]
  - leapAddr [109:140], leap 141, memVal [142:173], rs2 [174:178], trap 179
  - fDestReg [180:184], fbusW [185:248], FPRegWrite 249, mul 250
- `out`  out  [0:174]  MEM/WB bundle:
  - nextPC [0:31], aluResult [32:63], memData [64:95], destReg [96:100]
  - RegWrite 101, MemToReg 102, PCtoReg 103, fDestReg [104:108], fbusW [109:172], FPRegWrite 173, trap 174
- `mem_stall`  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- `dmem_req`  out  1  access request, registered.
- `dmem_we`  out  1  1 = store.
- `dmem_addr`  out  [0:31]  word address; bits [30:31] = 0.
- `dmem_be`  out  [0:3]  byte enables; bit 0 = byte at offset 0 = data [0:7] (big-endian).
- `dmem_wdata`  out  [0:31]  lane-replicated store data.
- `dmem_rdata`  in  [0:31]  load data; valid only with ack.
- `dmem_ack`  in  1  one-cycle completion pulse.
- `mem_misalign`  out  1  misaligned access detected (only with the macro).

## Operation
- Memory op: `MemToReg | MemWrite`, with `trap = 0`. Trapped instructions never access memory.
- DSize: 00 = byte, 01 = half, 10 and 11 = word.
- Byte enables:
  - byte: one-hot at addr[30:31]
  - half: 1100 at offset 0, 0011 at offset 2
  - word: 1111
- Store data replication: byte → {b,b,b,b}; half → {h,h}; word unchanged.
- Load format: select the addressed lane and right-justify it to bits [24:31]/[16:31]. Extend with sign when loadSign = 1, otherwise with zeros.
- FSM states:
  - IDLE: on a memory op, assert `mem_stall`, register req/we/addr/be/wdata, and go to WAIT. Otherwise `mem_stall` = 0 and stay.
  - WAIT: hold all dmem outputs stable and `mem_stall` = 1. On `dmem_ack`: drop req, capture the formatted load into `ld_q`, and go to DONE.
  - DONE: `mem_stall` = 0 for exactly one cycle; MEM/WB captures. Then go to IDLE.
- `out.memData` = `ld_q` in DONE; 0 otherwise. Every other `out` field is a combinational copy of `in`.
- A store writes `ld_q` = 0; its RegWrite is passed through unchanged.
- `RegToPC`, `leap`, `leapAddr`, `memVal`, `rs2` and `mul` are consumed upstream and ignored here.

## Timing
- Reset: state = IDLE; `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_be`, `dmem_wdata`, `ld_q`, `mem_misalign` = 0. `mem_stall` = 0 while reset is held.
- Non-memory instruction: zero added latency.
- Memory op presented in IDLE at cycle 0:
  - `dmem_req` is high from cycle 1.
  - With ack in cycle k ≥ 1, DONE is cycle k+1; the instruction occupies the stage for k+2 cycles.
- Ack outside WAIT is ignored.
- `dmem_req` never stays high for more than one cycle after ack.
- Reset mid-WAIT: `dmem_req` drops asynchronously and any late ack is ignored.
- Back-to-back memory ops: the second one's IDLE cycle immediately follows DONE, so there are 0 bubbles between them beyond the stall.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - In IDLE, a memory op with half at an odd address, or word with addr[30:31] ≠ 00, raises `mem_misalign` for one cycle.
  - No request is issued and there is no stall.
  - `out.trap` = 1 and `out.RegWrite` = 0.
- Undefined:
  - The address is forced aligned (half: addr[31] ignored; word: addr[30:31] ignored).
  - `mem_misalign` is tied to 0.

## Test plan
- ALU-only instruction, aluResult = 0x00000010, RegWrite = 1 → `mem_stall` = 0; out passes through with memData = 0 in the same cycle.
- Load word (loadSign = 1), addr 0x100, ack in cycle 3, rdata 0x89ABCDEF:
  - `dmem_req` high in cycles 1-3.
  - `mem_stall` high in cycles 0-3.
  - Cycle 4: memData = 0x89ABCDEF, `mem_stall` = 0.
- Loads from 0x103 with rdata 0x112233F0:
  - signed byte → memData = 0xFFFFFFF0
  - unsigned byte → memData = 0x000000F0
- Store half, opB = 0x0000BEEF, addr 0x202 → `dmem_be` = 0011, `dmem_wdata` = 0xBEEFBEEF, `dmem_addr` = 0x200, `dmem_we` = 1.
- Reset asserted in WAIT before ack → req drops in the same cycle and state = IDLE. A subsequent ack does not change out, and `mem_stall` = 0.
- With `MEM_ALIGN_CHECK_EN`, load word at 0x102 → `mem_misalign` pulse; no req; out.trap = 1, out.RegWrite = 0.
